// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and state encoding for the stopwatch timer controller
// Contents: state_t encoding, prescaler width, TICK_DIV / LIMIT_BCD defaults, BCD width.
package timer_pkg;

  localparam int BCD_W   = 16;
  localparam int PRESC_W = 20;

  localparam logic [PRESC_W-1:0] TICK_DIV_DEF  = 20'd100000;
  localparam logic [BCD_W-1:0]   LIMIT_BCD_DEF = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - 20-bit prescaler producing one registered wrap pulse per TICK_DIV enabled cycles
// Ports: clk, rst (async, active-high); enable advances the count; clear zeroes it
//        synchronously; wrap is high for one cycle after the count wraps TICK_DIV-1 -> 0.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter logic [PRESC_W-1:0] TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic wrap
);

  logic [PRESC_W-1:0] r_count;
  logic               r_wrap;
  logic               w_at_top;

  assign w_at_top = (r_count == (TICK_DIV - 20'd1));

  // A disabled prescaler simply holds its count, which is what keeps a
  // pause from gaining or losing part of a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (enable) begin
      if (w_at_top) begin
        r_count <= '0;
        r_wrap  <= 1'b1;
      end else begin
        r_count <= r_count + 20'd1;
        r_wrap  <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign wrap = r_wrap;

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - stopwatch control FSM driving a BCD counter_flop chain and character display
// Ports: clk, rst (async, active-high); start/stop/clear/lap one-cycle requests;
//        time_bcd chain value in; tick_out count enable and chain_rst clear to the chain;
//        running/expired/state status; display_bcd to the character display.
// Build option: define TIMER_CTRL_LAP_EN to enable the lap display-freeze feature.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter logic [PRESC_W-1:0] TICK_DIV  = TICK_DIV_DEF,
  parameter logic [BCD_W-1:0]   LIMIT_BCD = LIMIT_BCD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic [BCD_W-1:0] time_bcd,
  output logic             tick_out,
  output logic             chain_rst,
  output logic             running,
  output logic             expired,
  output logic [BCD_W-1:0] display_bcd,
  output logic [1:0]       state
);

  state_t           r_state;
  state_t           w_next;
  logic             w_presc_en;
  logic             w_wrap;
  logic             r_running;
  logic             r_expired;
  logic             r_chain_rst;
  logic [BCD_W-1:0] r_display;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state: clear beats everything; in RUN reaching the limit beats a pause.
  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (start) w_next = ST_RUN;
        ST_RUN: begin
          if (time_bcd == LIMIT_BCD) w_next = ST_EXPIRED;
          else if (stop)             w_next = ST_PAUSE;
        end
        ST_PAUSE:   if (start) w_next = ST_RUN;
        ST_EXPIRED: w_next = ST_EXPIRED;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // Prescaler runs on the registered RUN state, but not on the edge that
  // enters EXPIRED, so a wrap due on that edge never reaches the chain.
  always_comb begin
    w_presc_en = (r_state == ST_RUN) && (w_next != ST_EXPIRED);
  end

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .enable (w_presc_en),
    .clear  (clear),
    .wrap   (w_wrap)
  );

  // chain_rst resets high so the chain is held clear for the whole reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
      r_chain_rst <= 1'b1;
    end else begin
      r_running   <= (w_next == ST_RUN);
      r_expired   <= (w_next == ST_EXPIRED);
      r_chain_rst <= clear;
    end
  end

`ifdef TIMER_CTRL_LAP_EN
  logic r_freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_freeze <= 1'b0;
    else if (clear)
      r_freeze <= 1'b0;
    else if (lap && ((r_state == ST_RUN) || (r_state == ST_PAUSE)))
      r_freeze <= ~r_freeze;
  end

  // The value captured on the lap edge itself is the one held while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_display <= '0;
    else if (!r_freeze) r_display <= time_bcd;
  end
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_display <= '0;
    else     r_display <= time_bcd;
  end
`endif

  assign tick_out    = w_wrap;
  assign chain_rst   = r_chain_rst;
  assign running     = r_running;
  assign expired     = r_expired;
  assign display_bcd = r_display;
  assign state       = r_state;

endmodule
